// File: rtl/ctype_pkg.sv
// ctype_pkg: shared character-class definitions for the byte-stream lexer.
//   - CT_* class bits (upper, lower, digit, space, punct, control, hex, blank)
//   - CLASS_TABLE: 128-entry ASCII class table (index = 7-bit code)
//   - tok_kind_e: token kind codes driven on tok_kind
//   - tok_state_e: tokenizer FSM states
package ctype_pkg;

    localparam logic [7:0] CT_U = 8'h01;  // upper-case letter
    localparam logic [7:0] CT_L = 8'h02;  // lower-case letter
    localparam logic [7:0] CT_N = 8'h04;  // decimal digit
    localparam logic [7:0] CT_S = 8'h08;  // white space
    localparam logic [7:0] CT_P = 8'h10;  // punctuation
    localparam logic [7:0] CT_C = 8'h20;  // control
    localparam logic [7:0] CT_X = 8'h40;  // hex digit (0-9, a-f, A-F)
    localparam logic [7:0] CT_B = 8'h80;  // blank (space character)

    typedef enum logic [2:0] {
        TK_IDENT = 3'd0,
        TK_NUM   = 3'd1,
        TK_HEX   = 3'd2,
        TK_PUNCT = 3'd3,
        TK_ERR   = 3'd4,
        TK_EOM   = 3'd5
    } tok_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OPEN  = 2'd1,
        ST_FLUSH = 2'd2
    } tok_state_e;

    // Class of one 7-bit ASCII code. Digits carry the hex bit too so that a
    // hex literal continues uniformly on CT_X.
    function automatic logic [7:0] ascii_class(input logic [6:0] c);
        logic [7:0] cls;
        cls = 8'h00;
        if (c < 7'h20 || c == 7'h7F) cls = CT_C;
        if (c >= 7'h09 && c <= 7'h0D) cls = CT_C | CT_S;
        if (c == 7'h20) cls = CT_S | CT_B;
        if ((c >= 7'h21 && c <= 7'h2F) || (c >= 7'h3A && c <= 7'h40) ||
            (c >= 7'h5B && c <= 7'h60) || (c >= 7'h7B && c <= 7'h7E)) cls = CT_P;
        if (c >= 7'h30 && c <= 7'h39) cls = CT_N | CT_X;
        if (c >= 7'h41 && c <= 7'h46) cls = CT_U | CT_X;
        if (c >= 7'h47 && c <= 7'h5A) cls = CT_U;
        if (c >= 7'h61 && c <= 7'h66) cls = CT_L | CT_X;
        if (c >= 7'h67 && c <= 7'h7A) cls = CT_L;
        return cls;
    endfunction

    function automatic logic [127:0][7:0] build_class_table();
        logic [127:0][7:0] t;
        for (int i = 32'sd0; i < 32'sd128; i++) begin
            t[i] = ascii_class(7'(i));
        end
        return t;
    endfunction

    localparam logic [127:0][7:0] CLASS_TABLE = build_class_table();

endpackage

// File: rtl/ctype_classify.sv
// ctype_classify: combinational byte-to-class lookup.
//   ch  [7:0] in  : character byte
//   cls [7:0] out : CT_* class bits; 0 for bytes >= 0x80
module ctype_classify
    import ctype_pkg::*;
(
    input  logic [7:0] ch,
    output logic [7:0] cls
);

    // Table lookup; non-ASCII bytes have no class.
    always_comb begin
        if (ch[7]) begin
            cls = 8'h00;
        end else begin
            cls = CLASS_TABLE[ch[6:0]];
        end
    end

endmodule

// File: rtl/ctype_tokenizer.sv
// ctype_tokenizer: streaming lexer, one character per cycle in, one token per
// completed lexeme out (IDENT, NUM, HEX, PUNCT, ERR, EOM). Whitespace is skipped.
//   in_valid/in_ready/in_char/in_last : character stream (in_last marks message end)
//   tok_valid/tok_ready               : token handshake, fields held while stalled
//   tok_kind/tok_ofs/tok_len          : kind, start offset and length of the token
//   tok_last                          : final token of the message
//   tok_cont                          : token continues a length-saturated token
module ctype_tokenizer
    import ctype_pkg::*;
#(
    parameter int OFS_W = 16,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_char,
    input  logic             in_last,
    output logic             tok_valid,
    input  logic             tok_ready,
    output logic [2:0]       tok_kind,
    output logic [OFS_W-1:0] tok_ofs,
    output logic [LEN_W-1:0] tok_len,
    output logic             tok_last,
    output logic             tok_cont
);

    localparam logic [LEN_W-1:0] LEN_MAX  = {LEN_W{1'b1}};
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1'b1);
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [OFS_W-1:0] OFS_ONE  = OFS_W'(1'b1);
    localparam logic [OFS_W-1:0] OFS_ZERO = {OFS_W{1'b0}};

    tok_state_e       state_q, state_d;
    tok_kind_e        kind_q, kind_d;      // kind of the open / pending token
    logic [OFS_W-1:0] start_q, start_d;    // its first-character offset
    logic [LEN_W-1:0] len_q, len_d;
    logic             cont_q, cont_d;
    logic             zero_q, zero_d;      // its first character was '0'
    logic [OFS_W-1:0] ofs_q, ofs_d;        // offset of the next accepted char

    logic             out_valid_q, out_valid_d;
    tok_kind_e        out_kind_q, out_kind_d;
    logic [OFS_W-1:0] out_ofs_q, out_ofs_d;
    logic [LEN_W-1:0] out_len_q, out_len_d;
    logic             out_last_q, out_last_d;
    logic             out_cont_q, out_cont_d;

    logic [7:0]       cls_s;
    logic             out_free_s, accept_s, is_space_s, hex_switch_s, cont_ok_s;
    tok_kind_e        start_kind_s, next_kind_s;
    logic             ld_en_s, ld_last_s, ld_cont_s;
    tok_kind_e        ld_kind_s;
    logic [OFS_W-1:0] ld_ofs_s;
    logic [LEN_W-1:0] ld_len_s;

    ctype_classify u_classify (
        .ch  (in_char),
        .cls (cls_s)
    );

    assign out_free_s = !out_valid_q || tok_ready;
    assign in_ready   = (state_q != ST_FLUSH) && out_free_s;
    assign accept_s   = in_valid && in_ready;
    assign is_space_s = |(cls_s & CT_S);

    // "0x"/"0X" turns a one-digit NUM into a HEX literal.
    assign hex_switch_s = (kind_q == TK_NUM) && (len_q == LEN_ONE) && zero_q &&
                          (in_char == 8'h78 || in_char == 8'h58);
    assign next_kind_s  = hex_switch_s ? TK_HEX : kind_q;

    // Does the incoming char extend the open token, and what would it start.
    always_comb begin
        case (kind_q)
            TK_IDENT: cont_ok_s = |(cls_s & (CT_U | CT_L | CT_N));
            TK_NUM:   cont_ok_s = (|(cls_s & CT_N)) || hex_switch_s;
            TK_HEX:   cont_ok_s = |(cls_s & CT_X);
            default:  cont_ok_s = 1'b0;
        endcase
        if (|(cls_s & (CT_U | CT_L))) begin
            start_kind_s = TK_IDENT;
        end else if (|(cls_s & CT_N)) begin
            start_kind_s = TK_NUM;
        end else if (|(cls_s & CT_P)) begin
            start_kind_s = TK_PUNCT;
        end else begin
            start_kind_s = TK_ERR;
        end
    end

    // FSM next state, open-token bookkeeping and output-register load request.
    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        start_d   = start_q;
        len_d     = len_q;
        cont_d    = cont_q;
        zero_d    = zero_q;
        ofs_d     = ofs_q;
        ld_en_s   = 1'b0;
        ld_kind_s = TK_IDENT;
        ld_ofs_s  = OFS_ZERO;
        ld_len_s  = LEN_ZERO;
        ld_last_s = 1'b0;
        ld_cont_s = 1'b0;
        case (state_q)
            ST_FLUSH: begin
                if (out_free_s) begin
                    ld_en_s   = 1'b1;
                    ld_kind_s = kind_q;
                    ld_ofs_s  = start_q;
                    ld_len_s  = len_q;
                    ld_last_s = 1'b1;
                    ld_cont_s = cont_q;
                    state_d   = ST_IDLE;
                end else begin
                    state_d   = ST_FLUSH;
                end
            end
            ST_IDLE, ST_OPEN: begin
                if (accept_s) begin
                    if (in_last) begin
                        ofs_d = OFS_ZERO;
                    end else begin
                        ofs_d = ofs_q + OFS_ONE;
                    end
                    if ((state_q == ST_OPEN) && cont_ok_s) begin
                        if (len_q == LEN_MAX) begin
                            // Saturated: emit as is, restart same kind at c with cont set.
                            ld_en_s   = 1'b1;
                            ld_kind_s = kind_q;
                            ld_ofs_s  = start_q;
                            ld_len_s  = len_q;
                            ld_cont_s = cont_q;
                            kind_d    = next_kind_s;
                            start_d   = ofs_q;
                            len_d     = LEN_ONE;
                            cont_d    = 1'b1;
                            zero_d    = (in_char == 8'h30);
                            state_d   = in_last ? ST_FLUSH : ST_OPEN;
                        end else begin
                            kind_d = next_kind_s;
                            len_d  = len_q + LEN_ONE;
                            if (in_last) begin
                                ld_en_s   = 1'b1;
                                ld_kind_s = next_kind_s;
                                ld_ofs_s  = start_q;
                                ld_len_s  = len_q + LEN_ONE;
                                ld_last_s = 1'b1;
                                ld_cont_s = cont_q;
                                state_d   = ST_IDLE;
                            end else begin
                                state_d   = ST_OPEN;
                            end
                        end
                    end else begin
                        // c closes whatever is open and then starts its own token.
                        if (state_q == ST_OPEN) begin
                            ld_en_s   = 1'b1;
                            ld_kind_s = kind_q;
                            ld_ofs_s  = start_q;
                            ld_len_s  = len_q;
                            ld_last_s = in_last && is_space_s;
                            ld_cont_s = cont_q;
                        end else begin
                            ld_en_s   = 1'b0;
                        end
                        if (!is_space_s) begin
                            kind_d  = start_kind_s;
                            start_d = ofs_q;
                            len_d   = LEN_ONE;
                            cont_d  = 1'b0;
                            zero_d  = (in_char == 8'h30);
                            if (!in_last) begin
                                state_d = ST_OPEN;
                            end else if (state_q == ST_OPEN) begin
                                state_d = ST_FLUSH;
                            end else begin
                                ld_en_s   = 1'b1;
                                ld_kind_s = start_kind_s;
                                ld_ofs_s  = ofs_q;
                                ld_len_s  = LEN_ONE;
                                ld_last_s = 1'b1;
                                ld_cont_s = 1'b0;
                                state_d   = ST_IDLE;
                            end
                        end else begin
                            state_d = ST_IDLE;
                            if (in_last && (state_q == ST_IDLE)) begin
                                // Nothing to report: end-of-message marker at message length.
                                ld_en_s   = 1'b1;
                                ld_kind_s = TK_EOM;
                                ld_ofs_s  = ofs_q + OFS_ONE;
                                ld_len_s  = LEN_ZERO;
                                ld_last_s = 1'b1;
                                ld_cont_s = 1'b0;
                            end else begin
                                ld_en_s   = ld_en_s;
                            end
                        end
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output register next value: load a new token or drop valid once taken.
    always_comb begin
        if (ld_en_s) begin
            out_valid_d = 1'b1;
            out_kind_d  = ld_kind_s;
            out_ofs_d   = ld_ofs_s;
            out_len_d   = ld_len_s;
            out_last_d  = ld_last_s;
            out_cont_d  = ld_cont_s;
        end else begin
            out_valid_d = out_valid_q && !tok_ready;
            out_kind_d  = out_kind_q;
            out_ofs_d   = out_ofs_q;
            out_len_d   = out_len_q;
            out_last_d  = out_last_q;
            out_cont_d  = out_cont_q;
        end
    end

    // FSM state and open-token registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            kind_q  <= TK_IDENT;
            start_q <= OFS_ZERO;
            len_q   <= LEN_ZERO;
            cont_q  <= 1'b0;
            zero_q  <= 1'b0;
            ofs_q   <= OFS_ZERO;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            start_q <= start_d;
            len_q   <= len_d;
            cont_q  <= cont_d;
            zero_q  <= zero_d;
            ofs_q   <= ofs_d;
        end
    end

    // Single output token register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_kind_q  <= TK_IDENT;
            out_ofs_q   <= OFS_ZERO;
            out_len_q   <= LEN_ZERO;
            out_last_q  <= 1'b0;
            out_cont_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_kind_q  <= out_kind_d;
            out_ofs_q   <= out_ofs_d;
            out_len_q   <= out_len_d;
            out_last_q  <= out_last_d;
            out_cont_q  <= out_cont_d;
        end
    end

    assign tok_valid = out_valid_q;
    assign tok_kind  = out_kind_q;
    assign tok_ofs   = out_ofs_q;
    assign tok_len   = out_len_q;
    assign tok_last  = out_last_q;
    assign tok_cont  = out_cont_q;

endmodule

// File: tb/tb_ctype_tokenizer.sv
// Self-checking bench for ctype_tokenizer: two instances (LEN_W=8 and LEN_W=3)
// share one driver; a string-level lexer model predicts the token list.
module tb_ctype_tokenizer;

    typedef byte unsigned bq_t[$];
    typedef struct packed {
        logic [2:0]  kind;
        logic [15:0] ofs;
        logic [7:0]  len;
        logic        last;
        logic        cont;
    } tok_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       sel = 1'b0;
    logic       drv_valid = 1'b0, drv_last = 1'b0, drv_ready = 1'b0;
    logic [7:0] drv_char = 8'h00;

    logic in_valid_a, in_ready_a, tok_ready_a, tok_valid_a, tok_last_a, tok_cont_a;
    logic [2:0] tok_kind_a;  logic [15:0] tok_ofs_a;  logic [7:0] tok_len_a;
    logic in_valid_b, in_ready_b, tok_ready_b, tok_valid_b, tok_last_b, tok_cont_b;
    logic [2:0] tok_kind_b;  logic [15:0] tok_ofs_b;  logic [2:0] tok_len_b;

    assign in_valid_a  = drv_valid && !sel;
    assign tok_ready_a = drv_ready && !sel;
    assign in_valid_b  = drv_valid && sel;
    assign tok_ready_b = drv_ready && sel;

    ctype_tokenizer #(.OFS_W(16), .LEN_W(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_char(drv_char), .in_last(drv_last), .tok_valid(tok_valid_a), .tok_ready(tok_ready_a),
        .tok_kind(tok_kind_a), .tok_ofs(tok_ofs_a), .tok_len(tok_len_a),
        .tok_last(tok_last_a), .tok_cont(tok_cont_a));

    ctype_tokenizer #(.OFS_W(16), .LEN_W(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_char(drv_char), .in_last(drv_last), .tok_valid(tok_valid_b), .tok_ready(tok_ready_b),
        .tok_kind(tok_kind_b), .tok_ofs(tok_ofs_b), .tok_len(tok_len_b),
        .tok_last(tok_last_b), .tok_cont(tok_cont_b));

    logic cur_in_ready, cur_valid;
    tok_t cur_tok;
    always_comb begin
        if (sel) begin
            cur_in_ready = in_ready_b;
            cur_valid    = tok_valid_b;
            cur_tok      = {tok_kind_b, tok_ofs_b, 5'd0, tok_len_b, tok_last_b, tok_cont_b};
        end else begin
            cur_in_ready = in_ready_a;
            cur_valid    = tok_valid_a;
            cur_tok      = {tok_kind_a, tok_ofs_a, tok_len_a, tok_last_a, tok_cont_a};
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference lexer (string level) ----------------
    function automatic bit is_space(input byte unsigned c);
        return (c >= 8'h09 && c <= 8'h0D) || c == 8'h20;
    endfunction
    function automatic bit is_digit(input byte unsigned c);
        return c >= 8'h30 && c <= 8'h39;
    endfunction
    function automatic bit is_alpha(input byte unsigned c);
        return (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A);
    endfunction
    function automatic bit is_hex(input byte unsigned c);
        return is_digit(c) || (c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66);
    endfunction
    function automatic bit is_punct(input byte unsigned c);
        return (c >= 8'h21 && c <= 8'h2F) || (c >= 8'h3A && c <= 8'h40) ||
               (c >= 8'h5B && c <= 8'h60) || (c >= 8'h7B && c <= 8'h7E);
    endfunction

    function automatic void lex(input bq_t msg, input int maxl, output tok_t q[$]);
        int i = 0;
        int j;
        int n = msg.size();
        logic [2:0] k;
        tok_t t;
        q = {};
        while (i < n) begin
            if (is_space(msg[i])) begin
                i++;
                continue;
            end
            j = i + 1;
            if (is_alpha(msg[i])) begin
                k = 3'd0;
                while (j < n && (is_alpha(msg[j]) || is_digit(msg[j]))) j++;
            end else if (is_digit(msg[i])) begin
                if (msg[i] == 8'h30 && j < n && (msg[j] == 8'h78 || msg[j] == 8'h58)) begin
                    k = 3'd2;
                    j++;
                    while (j < n && is_hex(msg[j])) j++;
                end else begin
                    k = 3'd1;
                    while (j < n && is_digit(msg[j])) j++;
                end
            end else if (is_punct(msg[i])) begin
                k = 3'd3;
            end else begin
                k = 3'd4;
            end
            for (int s = i; s < j; s += maxl) begin
                t.kind = k;
                t.ofs  = 16'(s);
                t.len  = 8'((j - s) < maxl ? (j - s) : maxl);
                t.last = 1'b0;
                t.cont = (s != i);
                q.push_back(t);
            end
            i = j;
        end
        if (q.size() == 0) begin
            t = {3'd5, 16'(n), 8'd0, 1'b1, 1'b0};
            q.push_back(t);
        end else begin
            q[q.size() - 1].last = 1'b1;
        end
    endfunction

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // mode 0: random valid/ready; 1: full rate, ready low 5 cycles at first token; 2: full rate.
    task automatic run_msg(input bit d, input bq_t msg, input int mode, input bit chk_flush, input string name);
        tok_t exp_q[$];
        tok_t got_q[$];
        int idx = 0, cyc = 0, stall = 0;
        bit seen_first = 1'b0, hold = 1'b0, just_last = 1'b0;
        logic [29:0] held = '0;
        lex(msg, d ? 7 : 255, exp_q);
        sel = d;
        while ((idx < msg.size() || got_q.size() < exp_q.size()) && cyc < 3000) begin
            @(negedge clk);
            if (hold) check_eq({name, "_stable"}, {cur_valid, cur_tok}, held);
            drv_valid = (idx < msg.size()) && (mode != 0 || $urandom_range(0, 99) < 80);
            drv_char  = (idx < msg.size()) ? msg[idx] : 8'h00;
            drv_last  = (idx == msg.size() - 1);
            if (mode == 0) begin
                drv_ready = ($urandom_range(0, 99) < 70);
            end else begin
                if (mode == 1 && cur_valid && !seen_first) begin
                    seen_first = 1'b1;
                    stall = 5;
                end
                drv_ready = (stall == 0);
                if (stall > 0) stall--;
            end
            #1;
            if (cur_valid && !drv_ready) check_eq({name, "_in_ready_stall"}, cur_in_ready, 1'b0);
            if (just_last && chk_flush) check_eq({name, "_in_ready_flush"}, cur_in_ready, 1'b0);
            just_last = 1'b0;
            if (cur_valid && drv_ready) got_q.push_back(cur_tok);
            hold = cur_valid && !drv_ready;
            held = {cur_valid, cur_tok};
            if (drv_valid && cur_in_ready) begin
                just_last = drv_last;
                idx++;
            end
            cyc++;
        end
        @(posedge clk);
        #1;
        drv_valid = 1'b0;
        drv_last  = 1'b0;
        drv_ready = 1'b0;
        if (cyc >= 3000) check_eq({name, "_timeout"}, 1'b1, 1'b0);
        @(negedge clk);
        check_eq({name, "_idle_after"}, cur_valid, 1'b0);
        check_eq({name, "_count"}, got_q.size(), exp_q.size());
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
            check_eq($sformatf("%s_tok%0d", name, k), got_q[k], exp_q[k]);
    endtask

    function automatic bq_t rand_msg(input string pool);
        bq_t q;
        int n = $urandom_range(1, 20);
        int r;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, pool.len() + 2);
            if (r < pool.len()) q.push_back(pool[r]);
            else if (r == pool.len()) q.push_back(8'h07);
            else if (r == pool.len() + 1) q.push_back(8'hC3);
            else q.push_back(8'h7F);
        end
        return q;
    endfunction

    initial begin
        bq_t m;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sel = d[0];
            #1;
            check_eq($sformatf("reset_valid%0d", d), cur_valid, 1'b0);
            check_eq($sformatf("reset_fields%0d", d), cur_tok, '0);
            check_eq($sformatf("reset_in_ready%0d", d), cur_in_ready, 1'b1);
        end
        @(negedge clk);
        rst_n = 1'b1;

        run_msg(1'b0, str2q("ab1 0x1F;"), 2, 1'b1, "mixed");
        run_msg(1'b0, str2q("  "), 2, 1'b0, "eom");
        run_msg(1'b0, str2q("a"), 2, 1'b0, "after_eom");
        m = {8'h07, 8'hC3, 8'h61};
        run_msg(1'b0, m, 0, 1'b0, "err");
        run_msg(1'b1, str2q("abcdefghij"), 0, 1'b0, "sat");
        run_msg(1'b0, str2q("12+34"), 1, 1'b0, "stall");
        run_msg(1'b0, str2q("0xg 00x 09Zz\tA_"), 0, 1'b0, "edge");

        for (int i = 0; i < 40; i++)
            run_msg(1'b0, rand_msg("aZq09x5XfF +;_\t0"), 0, 1'b0, $sformatf("rndA%0d", i));
        for (int i = 0; i < 15; i++)
            run_msg(1'b1, rand_msg("abQzcde12 ;\t"), 0, 1'b0, $sformatf("rndB%0d", i));

        // Reset while a token is held and another is open.
        sel = 1'b0;
        @(negedge clk);
        drv_ready = 1'b0;
        drv_valid = 1'b1; drv_last = 1'b0; drv_char = 8'h61;
        @(negedge clk); drv_char = 8'h62;
        @(negedge clk); drv_char = 8'h20;
        @(negedge clk); drv_char = 8'h63;
        #1;
        check_eq("pre_rst_valid", cur_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_valid", cur_valid, 1'b0);
        check_eq("rst_fields", cur_tok, '0);
        check_eq("rst_in_ready", cur_in_ready, 1'b1);
        @(negedge clk);
        drv_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_msg(1'b0, str2q("x"), 2, 1'b0, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ctype_tokenizer.md
# ctype_tokenizer

Streaming lexer that sequences the shared 128-entry ASCII character-class table over a byte stream. It consumes one character per cycle and emits one token per completed lexeme: identifier, decimal number, hex number, punctuation, error or end-of-message. Whitespace is skipped. It sits between a byte source and parser/scoreboard logic in the resources test environment.

## Interface
- `OFS_W`, 16: width of the in-message character offset counter.
- `LEN_W`, 8: width of the token length field; max token length is 2^LEN_W−1.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  character present.
- `in_ready`  out  1  character accepted when `in_valid && in_ready`.
- `in_char`  in  8  character byte.
- `in_last`  in  1  last character of the message.
- `tok_valid`  out  1  token present.
- `tok_ready`  in  1  sink accepts the token.
- `tok_kind`  out  3  token kind: 0 IDENT, 1 NUM, 2 HEX, 3 PUNCT, 4 ERR, 5 EOM.
- `tok_ofs`  out  OFS_W  offset of the token's first character in the message.
- `tok_len`  out  LEN_W  token length in characters.
- `tok_last`  out  1  final token of the message.
- `tok_cont`  out  1  continuation of a length-saturated token.

## Operation
- Class of c = table entry for c < 128. For c ≥ 128 the class is 0.
- States:
  - IDLE: no open token.
  - OPEN: token kind K, start offset, length and cont flag held.
  - FLUSH: a final token is pending. `in_ready` is 0.
- How an accepted char c starts a token:
  - U or L starts IDENT.
  - N starts NUM.
  - P starts PUNCT.
  - S starts nothing.
  - Class 0 starts ERR.
- How an accepted char c continues an open token:
  - IDENT continues on U|L|N.
  - NUM continues on N.
  - NUM with length 1, first char '0', and c = 'x' or 'X' becomes HEX and continues.
  - HEX continues on X.
  - PUNCT and ERR never continue.
- A char that does not continue the open token closes that token. The closed token is loaded into the output register. The char then starts its own token, or is skipped if it is whitespace.
- Length saturation: if the length equals 2^LEN_W−1 and c would continue the token, the token is emitted with its own cont flag. A new token of the same kind starts at c with cont=1.
- `in_last` handling:
  - After the last char is processed, any open token becomes the final token with `tok_last`=1.
  - If the last char both closes a token and opens a new one, the closed token is emitted now. The new token is emitted from FLUSH on the next output slot.
  - If no token remains, an EOM token is emitted: len 0, `tok_ofs` = message length, `tok_last`=1.
- Offset counter: increments per accepted char and clears to 0 after the last char. It wraps modulo 2^OFS_W.

## Timing
- Reset values: `tok_valid`=0, all `tok_*` fields 0, state IDLE, offset 0. `in_ready`=1 after reset.
- `in_ready` = (state ≠ FLUSH) && (!`tok_valid` || `tok_ready`). This is combinational from `tok_ready`.
- A token is registered on the clock edge that accepts its terminating char. `tok_valid` rises the following cycle, giving 1-cycle latency.
- While `tok_valid && !tok_ready`, all `tok_*` fields are held stable and no char is accepted.
- Output accept and input accept may occur in the same cycle, giving full throughput of 1 char/cycle.
- FLUSH lasts until its token is loaded. The state then returns to IDLE.
- Reset asserted mid-token discards all open and pending state immediately.

## Structure
- Package `ctype_pkg` holds:
  - class bit constants U, L, N, S, P, C, X, B;
  - the 128-entry class table;
  - the token kind enum;
  - the state enum.
- Sub-module `ctype_classify` is combinational: byte in, 8-bit class out, returning 0 for c ≥ 128.
- `ctype_tokenizer` contains the FSM, the offset and length counters, and the single output register.

## Test plan
- "ab1 0x1F;" with `in_last` on ';' → IDENT ofs0 len3; HEX ofs4 len4; PUNCT ofs8 len1 last=1, the PUNCT emitted from FLUSH with `in_ready`=0 for that slot.
- Two spaces with `in_last` → single EOM ofs2 len0 last=1; next message starts at ofs0.
- 0x07 then 0xC3 then 'a' last → ERR ofs0 len1; ERR ofs1 len1; IDENT ofs2 len1 last=1.
- `LEN_W`=3, "abcdefghij" last → IDENT ofs0 len7 cont0; IDENT ofs7 len3 cont1 last=1.
- "12+34" last with `tok_ready` low for 5 cycles after the first token → `in_ready` 0 and `tok_*` stable throughout; tokens NUM(0,2), PUNCT(2,1), NUM(3,2,last) delivered in order with no loss.
- Assert `rst_n` low mid-"abc" → `tok_valid`=0 immediately; after release, "x" last → IDENT ofs0 len1 last=1.
